multicycle_ctrl_fsm: RTL

//  Main control FSM for the multicycle RV32I core. Sequences the shared ALU and the shared instruction/data memory port.

---
 rtl/multicycle_ctrl_fsm.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM for the multicycle RV32I core: sequences the shared ALU and
// the shared instruction/data memory port, stalling on the mem_ready handshake.
module multicycle_ctrl_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       instr_done,
  output logic       illegal_instr
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWRITE = 4'd4,
    S_MEMWB    = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11,
    S_AUIPC    = 4'd12
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_RTYPE = 7'h33;
  localparam logic [6:0] OP_ITYPE = 7'h13;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_JAL   = 7'h6F;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t     state_q, state_d;
  logic [2:0] alu_dec;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BR:             state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR, S_EXECI, S_JAL, S_AUIPC: state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    alu_dec = ALU_ADD;
    case (funct3)
      3'b000:  alu_dec = (op == OP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_dec = ALU_SLT;
      3'b100:  alu_dec = ALU_XOR;
      3'b110:  alu_dec = ALU_OR;
      3'b111:  alu_dec = ALU_AND;
      default: alu_dec = ALU_ADD;
    endcase
  end

  always_comb begin
    PCWrite       = 1'b0;
    AdrSrc        = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    RegWrite      = 1'b0;
    ResultSrc     = 2'b00;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    ImmSrc        = IMM_I;
    ALUControl    = ALU_ADD;
    instr_done    = 1'b0;
    illegal_instr = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = IMM_B;
        case (op)
          OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE,
          OP_BR, OP_JAL, OP_LUI, OP_AUIPC: illegal_instr = 1'b0;
          default:                          illegal_instr = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = (op == OP_LOAD) ? IMM_I : IMM_S;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        MemWrite   = 1'b1;
        instr_done = mem_ready;
      end
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_dec;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_dec;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        PCWrite    = (funct3 == 3'b000) ? Zero : (funct3 == 3'b001) ? ~Zero : 1'b0;
        instr_done = 1'b1;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      S_LUI: begin
        ImmSrc     = IMM_U;
        ResultSrc  = 2'b11;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_AUIPC: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = IMM_U;
      end
      default: ;
    endcase
    // Async reset already forces FETCH selects; only the enables need masking here.
    if (reset) begin
      PCWrite       = 1'b0;
      MemWrite      = 1'b0;
      IRWrite       = 1'b0;
      RegWrite      = 1'b0;
      instr_done    = 1'b0;
      illegal_instr = 1'b0;
    end
  end

endmodule
